// File: rtl/pid_sched_if.sv
// Error-sample handshake between the sensor pipeline (master) and pid_sched (slave).
interface pid_sched_if;
   logic               err_vld;
   logic               err_rdy;
   logic signed [12:0] error_in;

   modport master (output err_vld, output error_in, input err_rdy);
   modport slave  (input err_vld, input error_in, output err_rdy);
endinterface

// File: rtl/pid_sched.sv
// pid_sched: decimation strobe, one-entry error sample buffer, pedaling
// timeout and drive ramp FSM feeding a PID datapath.
// Optional build macro PID_SCHED_FAST_SIM_EN: forces a 2^15 clock tick period
// for fast simulation regardless of TICK_BITS.
module pid_sched #(
   parameter int unsigned TICK_BITS     = 20,
   parameter int unsigned PEDAL_TIMEOUT = 4,
   parameter logic [11:0] RAMP_STEP     = 12'd64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cadence,
   pid_sched_if.slave         err_if,
   output logic signed [12:0] error_out,
   output logic               pid_tick,
   output logic               not_pedaling,
   input  logic [11:0]        drv_mag_in,
   output logic [11:0]        drv_mag_out,
   output logic [1:0]         state,
   output logic               err_stale
);

`ifdef PID_SCHED_FAST_SIM_EN
   localparam int unsigned CNT_W = 15;
`else
   localparam int unsigned CNT_W = TICK_BITS;
`endif

   localparam logic [CNT_W-1:0] CNT_PRE_MAX = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic [3:0]       TIMEOUT_CNT = 4'(PEDAL_TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic               pid_tick_q, pid_tick_d;
   logic [3:0]         idle_cnt_q, idle_cnt_d;
   logic               full_q, full_d;
   logic signed [12:0] hold_q, hold_d;
   logic signed [12:0] error_out_q, error_out_d;
   logic               err_stale_q, err_stale_d;

   state_t             state_q;
   logic [11:0]        drv_mag_q;
   logic               not_pedaling_q;

   logic               timeout;
   logic [12:0]        up_sum;
   logic [11:0]        up_capped;
   logic [11:0]        dn_floor;

   // Free-running tick counter; the strobe is registered so it is high exactly
   // while the counter sits at all-ones.
   always_comb begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
      pid_tick_d = (tick_cnt_q == CNT_PRE_MAX);
   end

   // Idle counter: cadence clears (and beats a coincident tick), ticks count up
   // and saturate at the timeout value.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (cadence) begin
         idle_cnt_d = 4'd0;
      end else if (pid_tick_q && (idle_cnt_q < TIMEOUT_CNT)) begin
         idle_cnt_d = idle_cnt_q + 4'd1;
      end
   end

   assign timeout = (idle_cnt_q == TIMEOUT_CNT);

   // One-entry sample buffer: a tick drains it into error_out, or flags a
   // stale period if it was empty. Capture is only possible while empty, so it
   // never collides with a drain.
   always_comb begin
      full_d      = full_q;
      hold_d      = hold_q;
      error_out_d = error_out_q;
      err_stale_d = err_stale_q;
      if (pid_tick_q) begin
         if (full_q) begin
            error_out_d = hold_q;
            full_d      = 1'b0;
         end else begin
            err_stale_d = 1'b1;
         end
      end
      if (err_if.err_vld && !full_q) begin
         hold_d = err_if.error_in;
         full_d = 1'b1;
      end
   end

   // Ramp arithmetic: 13-bit sum so the upward step cannot wrap past 4095.
   always_comb begin
      up_sum    = {1'b0, drv_mag_q} + {1'b0, RAMP_STEP};
      up_capped = (up_sum > {1'b0, drv_mag_in}) ? drv_mag_in : up_sum[11:0];
      dn_floor  = (drv_mag_q > RAMP_STEP) ? (drv_mag_q - RAMP_STEP) : 12'd0;
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q  <= '0;
         pid_tick_q  <= 1'b0;
         idle_cnt_q  <= 4'd0;
         full_q      <= 1'b0;
         hold_q      <= '0;
         error_out_q <= '0;
         err_stale_q <= 1'b0;
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         pid_tick_q  <= pid_tick_d;
         idle_cnt_q  <= idle_cnt_d;
         full_q      <= full_d;
         hold_q      <= hold_d;
         error_out_q <= error_out_d;
         err_stale_q <= err_stale_d;
      end
   end

   // Drive FSM with registered drive and integrator-clear outputs. Timeout is
   // a level, so leaving START/RUN does not wait for the next tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         drv_mag_q      <= 12'd0;
         not_pedaling_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               drv_mag_q <= 12'd0;
               if (cadence) begin
                  state_q        <= ST_START;
                  not_pedaling_q <= 1'b0;
               end
            end
            ST_START: begin
               if (timeout) begin
                  state_q        <= ST_STOP;
                  not_pedaling_q <= 1'b1;
               end else if (pid_tick_q) begin
                  drv_mag_q <= up_capped;
                  if (up_capped == drv_mag_in) begin
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               drv_mag_q <= drv_mag_in;
               if (timeout) begin
                  state_q        <= ST_STOP;
                  not_pedaling_q <= 1'b1;
               end
            end
            ST_STOP: begin
               if (cadence) begin
                  state_q        <= ST_START;
                  not_pedaling_q <= 1'b0;
               end else if (pid_tick_q) begin
                  drv_mag_q <= dn_floor;
                  if (dn_floor == 12'd0) begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_q        <= ST_IDLE;
               drv_mag_q      <= 12'd0;
               not_pedaling_q <= 1'b1;
            end
         endcase
      end
   end

   assign err_if.err_rdy = !full_q;
   assign error_out      = error_out_q;
   assign pid_tick       = pid_tick_q;
   assign not_pedaling   = not_pedaling_q;
   assign drv_mag_out    = drv_mag_q;
   assign state          = state_q;
   assign err_stale      = err_stale_q;

endmodule

// File: tb/tb_pid_sched.sv
// Directed self-checking bench for pid_sched (short tick period).
module tb_pid_sched;
   localparam int TB_TICK_BITS = 6;
`ifdef PID_SCHED_FAST_SIM_EN
   localparam int P = 32768;
`else
   localparam int P = 1 << TB_TICK_BITS;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               cadence = 1'b0;
   logic signed [12:0] error_out;
   logic               pid_tick;
   logic               not_pedaling;
   logic [11:0]        drv_mag_in = 12'd0;
   logic [11:0]        drv_mag_out;
   logic [1:0]         state;
   logic               err_stale;

   int total = 0;
   int bad   = 0;

   pid_sched_if err_if ();

   pid_sched #(
      .TICK_BITS    (TB_TICK_BITS),
      .PEDAL_TIMEOUT(4),
      .RAMP_STEP    (12'd64)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cadence     (cadence),
      .err_if      (err_if.slave),
      .error_out   (error_out),
      .pid_tick    (pid_tick),
      .not_pedaling(not_pedaling),
      .drv_mag_in  (drv_mag_in),
      .drv_mag_out (drv_mag_out),
      .state       (state),
      .err_stale   (err_stale)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic pulse_cadence();
      cadence = 1'b1;
      step();
      cadence = 1'b0;
   endtask

   // Leaves the bench 1 time unit after the edge that raised pid_tick.
   task automatic wait_tick(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2 * P; i++) begin
         step();
         if (pid_tick) begin
            seen = 1'b1;
            break;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s_tick_timeout: got no pid_tick, want one within %0d cycles", tag, 2 * P);
      end
   endtask

   task automatic test_reset();
      int first_hi, second_hi, hi_count;
      do_reset();
      total++;
      if (state !== 2'd0 || not_pedaling !== 1'b1 || drv_mag_out !== 12'd0) begin
         bad++;
         $display("FAIL reset_fsm: got state=%0d np=%0b drv=%0d, want 0 1 0", state, not_pedaling, drv_mag_out);
      end
      total++;
      if (pid_tick !== 1'b0 || err_stale !== 1'b0 || error_out !== 13'sd0 || err_if.err_rdy !== 1'b1) begin
         bad++;
         $display("FAIL reset_data: got tick=%0b stale=%0b eout=%0d rdy=%0b, want 0 0 0 1",
                  pid_tick, err_stale, error_out, err_if.err_rdy);
      end
      first_hi = -1; second_hi = -1; hi_count = 0;
      for (int n = 1; n <= 2 * P; n++) begin
         step();
         if (pid_tick === 1'b1) begin
            hi_count++;
            if (first_hi < 0) first_hi = n;
            else if (second_hi < 0) second_hi = n;
         end
      end
      total++;
      if (first_hi !== P - 1) begin
         bad++;
         $display("FAIL tick_first: got cycle %0d, want %0d", first_hi, P - 1);
      end
      total++;
      if (second_hi !== 2 * P - 1) begin
         bad++;
         $display("FAIL tick_second: got cycle %0d, want %0d", second_hi, 2 * P - 1);
      end
      total++;
      if (hi_count !== 2) begin
         bad++;
         $display("FAIL tick_width: got %0d high cycles, want 2", hi_count);
      end
      total++;
      if (state !== 2'd0 || not_pedaling !== 1'b1 || drv_mag_out !== 12'd0 || err_stale !== 1'b1) begin
         bad++;
         $display("FAIL idle_run: got state=%0d np=%0b drv=%0d stale=%0b, want 0 1 0 1",
                  state, not_pedaling, drv_mag_out, err_stale);
      end
      $display("test_reset: ticks at %0d and %0d", first_hi, second_hi);
   endtask

   task automatic test_sample();
      logic signed [12:0] exp_a, exp_b;
      exp_a = -13'sd5;
      exp_b = 13'sd7;
      do_reset();
      err_if.err_vld  = 1'b1;
      err_if.error_in = exp_a;
      step();
      err_if.error_in = exp_b;
      total++;
      if (err_if.err_rdy !== 1'b0) begin
         bad++;
         $display("FAIL smp_full: got rdy=%0b, want 0", err_if.err_rdy);
      end
      wait_tick("smp1");
      total++;
      if (err_if.err_rdy !== 1'b0) begin
         bad++;
         $display("FAIL smp_hold_until_tick: got rdy=%0b, want 0", err_if.err_rdy);
      end
      step();
      total++;
      if (error_out !== exp_a || err_if.err_rdy !== 1'b1) begin
         bad++;
         $display("FAIL smp_drain: got eout=%0d rdy=%0b, want -5 1", error_out, err_if.err_rdy);
      end
      step();
      err_if.err_vld = 1'b0;
      total++;
      if (err_if.err_rdy !== 1'b0 || err_stale !== 1'b0) begin
         bad++;
         $display("FAIL smp_second_accept: got rdy=%0b stale=%0b, want 0 0", err_if.err_rdy, err_stale);
      end
      wait_tick("smp2");
      step();
      total++;
      if (error_out !== exp_b || err_stale !== 1'b0) begin
         bad++;
         $display("FAIL smp_second_out: got eout=%0d stale=%0b, want 7 0", error_out, err_stale);
      end
      wait_tick("smp3");
      step();
      total++;
      if (err_stale !== 1'b1 || error_out !== exp_b) begin
         bad++;
         $display("FAIL smp_stale: got stale=%0b eout=%0d, want 1 7", err_stale, error_out);
      end
      $display("test_sample: error_out=%0d err_stale=%0b", error_out, err_stale);
   endtask

   task automatic test_ramp();
      int up_exp[4] = '{64, 128, 192, 200};
      int dn_exp[4] = '{136, 72, 8, 0};
      do_reset();
      drv_mag_in = 12'd200;
      step();
      pulse_cadence();
      total++;
      if (state !== 2'd1 || not_pedaling !== 1'b0 || drv_mag_out !== 12'd0) begin
         bad++;
         $display("FAIL ramp_enter_start: got state=%0d np=%0b drv=%0d, want 1 0 0", state, not_pedaling, drv_mag_out);
      end
      for (int i = 0; i < 4; i++) begin
         wait_tick("ramp_up");
         step();
         total++;
         if (drv_mag_out !== 12'(up_exp[i])) begin
            bad++;
            $display("FAIL ramp_up_%0d: got drv=%0d, want %0d", i, drv_mag_out, up_exp[i]);
         end
      end
      total++;
      if (state !== 2'd2) begin
         bad++;
         $display("FAIL ramp_run: got state=%0d, want 2", state);
      end
      step();
      total++;
      if (state !== 2'd3 || not_pedaling !== 1'b1 || drv_mag_out !== 12'd200) begin
         bad++;
         $display("FAIL ramp_timeout_stop: got state=%0d np=%0b drv=%0d, want 3 1 200", state, not_pedaling, drv_mag_out);
      end
      for (int i = 0; i < 4; i++) begin
         wait_tick("ramp_dn");
         step();
         total++;
         if (drv_mag_out !== 12'(dn_exp[i])) begin
            bad++;
            $display("FAIL ramp_dn_%0d: got drv=%0d, want %0d", i, drv_mag_out, dn_exp[i]);
         end
      end
      total++;
      if (state !== 2'd0 || not_pedaling !== 1'b1) begin
         bad++;
         $display("FAIL ramp_idle: got state=%0d np=%0b, want 0 1", state, not_pedaling);
      end
      $display("test_ramp: final state=%0d drv=%0d", state, drv_mag_out);
   endtask

   task automatic test_resume();
      do_reset();
      drv_mag_in = 12'd200;
      step();
      pulse_cadence();
      for (int i = 0; i < 6; i++) begin
         wait_tick("resume");
         step();
      end
      step();
      total++;
      if (state !== 2'd3 || drv_mag_out !== 12'd72) begin
         bad++;
         $display("FAIL resume_pre: got state=%0d drv=%0d, want 3 72", state, drv_mag_out);
      end
      pulse_cadence();
      total++;
      if (state !== 2'd1 || drv_mag_out !== 12'd72 || not_pedaling !== 1'b0) begin
         bad++;
         $display("FAIL resume_start: got state=%0d drv=%0d np=%0b, want 1 72 0", state, drv_mag_out, not_pedaling);
      end
      wait_tick("resume_up");
      step();
      total++;
      if (drv_mag_out !== 12'd136 || state !== 2'd1) begin
         bad++;
         $display("FAIL resume_ramp: got drv=%0d state=%0d, want 136 1", drv_mag_out, state);
      end
      $display("test_resume: drv=%0d", drv_mag_out);
   endtask

   task automatic test_saturate();
      bit seen;
      do_reset();
      drv_mag_in = 12'd0;
      step();
      pulse_cadence();
      wait_tick("sat0");
      step();
      total++;
      if (state !== 2'd2 || drv_mag_out !== 12'd0) begin
         bad++;
         $display("FAIL sat_clamp_run: got state=%0d drv=%0d, want 2 0", state, drv_mag_out);
      end
      drv_mag_in = 12'd4064;
      step();
      total++;
      if (drv_mag_out !== 12'd4064) begin
         bad++;
         $display("FAIL sat_follow: got drv=%0d, want 4064", drv_mag_out);
      end
      seen = 1'b0;
      for (int i = 0; i < 6 * P; i++) begin
         step();
         if (state === 2'd3) begin
            seen = 1'b1;
            break;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL sat_stop_timeout: got state=%0d, want 3 within %0d cycles", state, 6 * P);
      end
      pulse_cadence();
      drv_mag_in = 12'd4095;
      total++;
      if (state !== 2'd1 || drv_mag_out !== 12'd4064) begin
         bad++;
         $display("FAIL sat_start: got state=%0d drv=%0d, want 1 4064", state, drv_mag_out);
      end
      wait_tick("sat1");
      step();
      total++;
      if (drv_mag_out !== 12'd4095 || state !== 2'd2) begin
         bad++;
         $display("FAIL sat_nowrap: got drv=%0d state=%0d, want 4095 2", drv_mag_out, state);
      end
      $display("test_saturate: drv=%0d", drv_mag_out);
   endtask

   task automatic test_mid_reset();
      do_reset();
      drv_mag_in = 12'd200;
      step();
      pulse_cadence();
      wait_tick("mr0");
      step();
      err_if.err_vld  = 1'b1;
      err_if.error_in = 13'sd9;
      step();
      err_if.err_vld  = 1'b0;
      wait_tick("mr1");
      step();
      total++;
      if (error_out !== 13'sd9 || drv_mag_out !== 12'd128 || err_stale !== 1'b1) begin
         bad++;
         $display("FAIL mr_pre: got eout=%0d drv=%0d stale=%0b, want 9 128 1", error_out, drv_mag_out, err_stale);
      end
      err_if.err_vld  = 1'b1;
      err_if.error_in = 13'sd11;
      step();
      err_if.err_vld  = 1'b0;
      total++;
      if (err_if.err_rdy !== 1'b0) begin
         bad++;
         $display("FAIL mr_full: got rdy=%0b, want 0", err_if.err_rdy);
      end
      rst = 1'b1;
      step();
      total++;
      if (state !== 2'd0 || drv_mag_out !== 12'd0 || not_pedaling !== 1'b1 || pid_tick !== 1'b0) begin
         bad++;
         $display("FAIL mr_fsm: got state=%0d drv=%0d np=%0b tick=%0b, want 0 0 1 0",
                  state, drv_mag_out, not_pedaling, pid_tick);
      end
      total++;
      if (err_stale !== 1'b0 || error_out !== 13'sd0 || err_if.err_rdy !== 1'b1) begin
         bad++;
         $display("FAIL mr_data: got stale=%0b eout=%0d rdy=%0b, want 0 0 1", err_stale, error_out, err_if.err_rdy);
      end
      rst = 1'b0;
      step();
      total++;
      if (err_if.err_rdy !== 1'b1 || state !== 2'd0) begin
         bad++;
         $display("FAIL mr_release: got rdy=%0b state=%0d, want 1 0", err_if.err_rdy, state);
      end
      $display("test_mid_reset: state=%0d rdy=%0b", state, err_if.err_rdy);
   endtask

   initial begin
      err_if.err_vld  = 1'b0;
      err_if.error_in = 13'sd0;
      test_reset();
      test_sample();
      test_ramp();
      test_resume();
      test_saturate();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
